ring_rr_arbiter: RTL

Round-robin arbiter that shares one resource among N requesters. A one-hot ring pointer rotates after every grant, so the requester after the last winner gets highest priority next. A hold counter bounds how long one requester can keep the resource. The block sits in front of any shared datapath element (bus port, counter bank, memory) and drives its one-hot select.

---
 rtl/ring_rr_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with a one-hot rotating priority
// pointer and a per-grant hold limit. Drives a one-hot select for a shared
// resource; every output is registered.
module ring_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic          clk,
    input  logic          rst,          // asynchronous, active-low
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [N-1:0]  ptr,
    output logic [HW-1:0] hold_cnt,
    output logic          preempt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Last permitted hold count; reaching it with the request still high
    // forces a hand-off on the following edge.
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    grant_nxt;
    logic [N-1:0]    ptr_nxt;
    logic [HW-1:0]   hold_nxt;
    logic            preempt_nxt;
    logic [N-1:0]    rel_ptr;
    logic [N-1:0]    win;
    logic            req_hit;
    logic            hold_on;

    // Picks the first set request scanning upward (with wrap) from the
    // pointer bit. The requests are rotated so the pointer position lands
    // on bit 0, the lowest set bit is isolated, and the result is rotated
    // back into place. Returns all-zero when no request is set.
    function automatic logic [N-1:0] pick_winner(input logic [N-1:0] r,
                                                 input logic [N-1:0] p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [N-1:0]   iso;
        int             base;
        base = 0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                base = i;
            end
        end
        dbl = {r, r} >> base;
        rot = dbl[N-1:0];
        iso = rot & (-rot);
        dbl = {iso, iso} << base;
        return dbl[2*N-1:N];
    endfunction

    // Pointer after a release: the requester just above the current winner.
    assign rel_ptr = {grant[N-2:0], grant[N-1]};

    // Granted requester still asking, and still inside its hold budget.
    assign req_hit = |(req & grant);
    assign hold_on = req_hit && (hold_cnt != HOLD_LAST);

    // Next-state and next-output selection for the IDLE/BUSY machine.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        preempt_nxt = 1'b0;
        win         = '0;
        case (state)
            IDLE: begin
                win = pick_winner(req, ptr);
                if (|req) begin
                    grant_nxt = win;
                    hold_nxt  = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (hold_on) begin
                    hold_nxt = hold_cnt + HW'(1);
                end else begin
                    // Release: the releasing requester drops to lowest
                    // priority and the next winner is taken in the same
                    // edge, so there is no idle bubble between owners.
                    ptr_nxt     = rel_ptr;
                    win         = pick_winner(req, rel_ptr);
                    grant_nxt   = win;
                    hold_nxt    = '0;
                    preempt_nxt = req_hit;
                    state_nxt   = (|win) ? BUSY : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    // State and output registers; reset forces the idle, pointer-at-0 state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= {{(N-1){1'b0}}, 1'b1};
            hold_cnt    <= '0;
            preempt     <= 1'b0;
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            grant_valid <= |grant_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            preempt     <= preempt_nxt;
        end
    end

endmodule
